// File: rtl/cue_pkg.sv
// Shared types for the cue sequencer: FSM state encoding and cue color codes.
package cue_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ON,
        ST_GAP
    } cue_state_e;

    localparam logic [1:0] RED    = 2'b00;
    localparam logic [1:0] BLUE   = 2'b01;
    localparam logic [1:0] GREEN  = 2'b10;
    localparam logic [1:0] YELLOW = 2'b11;

endpackage

// File: rtl/cue_fifo.sv
// Show-ahead DEPTH x 2-bit cue FIFO with async reset and synchronous flush.
// Full is registered; count_next lets the owner register flags derived from occupancy.
module cue_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  logic [1:0]             wr_data,
    output logic [1:0]             rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic [$clog2(DEPTH):0] count_next
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [1:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    always_comb begin
        if (flush) count_next = '0;
        else       count_next = count + CW'(do_push) - CW'(do_pop);
    end

    // NOTE: storage has no reset; the pointers and count alone define what is valid.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else begin
            count <= count_next;
            full  <= (count_next == CW'(DEPTH));
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + AW'(1);
                if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

endmodule

// File: rtl/cue_sequencer.sv
// Plays queued color cues as timed on/off strobe pairs on the LED and audio peripherals.
// Define CUE_AUDIO_EN to drive the audio outputs; otherwise they are tied to 0.
module cue_sequencer
    import cue_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int ON_CYCLES  = 25_000_000,
    parameter int GAP_CYCLES = 12_500_000
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [1:0]             wr_color,
    input  logic                   flush,
    output logic                   full,
    output logic                   busy,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] pending,
    output logic                   led_flash,
    output logic [1:0]             led_color,
    output logic                   led_on,
    output logic                   audio_play,
    output logic [2:0]             audio_color,
    output logic                   audio_on
);
    localparam int CNT_MAX = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] ON_LOAD  = CW'(ON_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYCLES - 1);

    cue_state_e              state, state_d;
    logic [CW-1:0]           cnt, cnt_d;
    logic                    flash_d, on_d, pop, empty;
    logic [1:0]              color_d, head;
    logic [$clog2(DEPTH):0]  count_next;

    cue_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .flush      (flush),
        .push       (wr_en),
        .pop        (pop),
        .wr_data    (wr_color),
        .rd_data    (head),
        .full       (full),
        .empty      (empty),
        .count      (pending),
        .count_next (count_next)
    );

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        flash_d = 1'b0;
        color_d = led_color;
        on_d    = led_on;
        pop     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (!flush && !empty) begin
                    pop     = 1'b1;
                    flash_d = 1'b1;
                    on_d    = 1'b1;
                    color_d = head;
                    cnt_d   = ON_LOAD;
                    state_d = ST_ON;
                end
            end
            ST_ON: begin
                // A flush cuts the on-phase short but still turns the peripherals off.
                if (flush || cnt == '0) begin
                    flash_d = 1'b1;
                    on_d    = 1'b0;
                    state_d = flush ? ST_IDLE : ST_GAP;
                    cnt_d   = flush ? '0 : GAP_LOAD;
                end else begin
                    cnt_d = cnt - CW'(1);
                end
            end
            ST_GAP: begin
                if (flush) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt == '0) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        flash_d = 1'b1;
                        on_d    = 1'b1;
                        color_d = head;
                        cnt_d   = ON_LOAD;
                        state_d = ST_ON;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt - CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            led_flash <= 1'b0;
            led_color <= 2'b00;
            led_on    <= 1'b0;
            busy      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            led_flash <= flash_d;
            led_color <= color_d;
            led_on    <= on_d;
            busy      <= (state_d != ST_IDLE) || (count_next != '0);
            if (flush)              overflow <= 1'b0;
            else if (wr_en && full) overflow <= 1'b1;
        end
    end

`ifdef CUE_AUDIO_EN
    assign audio_play  = led_flash;
    assign audio_color = {1'b0, led_color};
    assign audio_on    = led_on;
`else
    assign audio_play  = 1'b0;
    assign audio_color = 3'b000;
    assign audio_on    = 1'b0;
`endif

endmodule

// File: tb/tb_cue_sequencer.sv
// Randomized and directed bench for cue_sequencer against a schedule-level reference model.
module tb_cue_sequencer;
    localparam int ON   = 4;
    localparam int GAP  = 2;
    localparam int D    = 4;
    localparam int MAXN = 200;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 1'b0;
    logic [1:0] wr_color = 2'b00;
    logic       flush = 1'b0;
    logic       full, busy, overflow, led_flash, led_on, audio_play, audio_on;
    logic [2:0] pending;
    logic [1:0] led_color;
    logic [2:0] audio_color;

    int tests_run = 0;
    int tests_failed = 0;

    cue_sequencer #(.DEPTH(D), .ON_CYCLES(ON), .GAP_CYCLES(GAP)) dut (
        .clock       (clock),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_color    (wr_color),
        .flush       (flush),
        .full        (full),
        .busy        (busy),
        .overflow    (overflow),
        .pending     (pending),
        .led_flash   (led_flash),
        .led_color   (led_color),
        .led_on      (led_on),
        .audio_play  (audio_play),
        .audio_color (audio_color),
        .audio_on    (audio_on)
    );

    always #5 clock = ~clock;

    // {flash, color, on, pending, full, busy, overflow, audio_play, audio_color, audio_on}
    wire [14:0] act = {led_flash, led_color, led_on, pending, full, busy, overflow,
                       audio_play, audio_color, audio_on};

    // Write schedule for one scenario, indexed by cycle.
    bit         sch_wr  [MAXN];
    logic [1:0] sch_col [MAXN];

    // Model: accepted cues with write cycle and on-strobe cycle; first dropped write.
    int         n_acc;
    int         acc_w   [MAXN];
    int         acc_on  [MAXN];
    logic [1:0] acc_col [MAXN];
    int         drop_first;

    function automatic logic [14:0] pack_exp(input bit fl, input logic [1:0] col, input bit on,
                                             input int pend, input bit fu, input bit bz, input bit ov);
        logic [4:0] aud;
`ifdef CUE_AUDIO_EN
        aud = {fl, 1'b0, col, on};
`else
        aud = 5'b0;
`endif
        return {fl, col, on, 3'(pend), fu, bz, ov, aud};
    endfunction

    task automatic clear_sched();
        for (int i = 0; i < MAXN; i++) begin
            sch_wr[i]  = 1'b0;
            sch_col[i] = 2'b00;
        end
    endtask

    // A cue written in cycle w is visible from w+1, so it can start no earlier than w+2,
    // and no earlier than one full ON+GAP period after the previous cue started.
    task automatic build_model(input int n);
        n_acc = 0;
        drop_first = -1;
        for (int w = 0; w < n; w++) begin
            if (sch_wr[w]) begin
                int occ;
                int t;
                occ = 0;
                for (int k = 0; k < n_acc; k++) begin
                    if (acc_w[k] + 1 <= w) occ++;
                    if (acc_on[k] <= w) occ--;
                end
                if (occ >= D) begin
                    if (drop_first < 0) drop_first = w;
                end else begin
                    t = w + 2;
                    if (n_acc > 0 && acc_on[n_acc-1] + ON + GAP > t) t = acc_on[n_acc-1] + ON + GAP;
                    acc_w[n_acc]   = w;
                    acc_col[n_acc] = sch_col[w];
                    acc_on[n_acc]  = t;
                    n_acc++;
                end
            end
        end
    endtask

    function automatic logic [14:0] expect_vec(input int c);
        bit fl, on, bz;
        logic [1:0] col;
        int pend;
        fl = 0; on = 0; bz = 0; col = 2'b00; pend = 0;
        for (int k = 0; k < n_acc; k++) begin
            if (acc_on[k] == c || acc_on[k] + ON == c) fl = 1;
            if (acc_on[k] <= c) col = acc_col[k];
            if (acc_on[k] <= c && c < acc_on[k] + ON) on = 1;
            if (acc_on[k] <= c && c < acc_on[k] + ON + GAP) bz = 1;
            if (acc_w[k] + 1 <= c) pend++;
            if (acc_on[k] <= c) pend--;
        end
        if (pend != 0) bz = 1;
        return pack_exp(fl, col, on, pend, pend == D, bz, drop_first >= 0 && drop_first + 1 <= c);
    endfunction

    // Checks cycles 0..n-1 of the current schedule; returns just after the cycle n-1 drive.
    task automatic run_sched(input string name, input int n);
        logic [14:0] exp_v;
        build_model(n);
        for (int c = 0; c < n; c++) begin
            @(negedge clock);
            exp_v = expect_vec(c);
            tests_run++;
            if (act !== exp_v) begin
                tests_failed++;
                $display("FAIL %s cycle %0d: got %b expected %b", name, c, act, exp_v);
            end
            wr_en    = sch_wr[c];
            wr_color = sch_col[c];
        end
    endtask

    task automatic check_vec(input string name, input logic [14:0] exp_v);
        tests_run++;
        if (act !== exp_v) begin
            tests_failed++;
            $display("FAIL %s: got %b expected %b", name, act, exp_v);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; wr_en = 1'b0; flush = 1'b0; wr_color = 2'b00;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clock);
        check_vec("reset_state", 15'b0);
        do_reset();
    endtask

    task automatic test_single_blue();
        do_reset();
        clear_sched();
        sch_wr[0] = 1; sch_col[0] = 2'b01;
        run_sched("single_blue", 12);
    endtask

    task automatic test_back_to_back();
        do_reset();
        clear_sched();
        sch_wr[0] = 1; sch_col[0] = 2'b00;
        sch_wr[1] = 1; sch_col[1] = 2'b10;
        sch_wr[2] = 1; sch_col[2] = 2'b11;
        run_sched("back_to_back", 24);
    endtask

    task automatic test_overflow();
        do_reset();
        clear_sched();
        for (int i = 0; i < 6; i++) begin
            sch_wr[i]  = 1;
            sch_col[i] = 2'($urandom_range(0, 3));
        end
        run_sched("overflow", 12);
        @(negedge clock);                               // cycle 12: GAP after second cue
        check_vec("overflow_sticky", expect_vec(12));
        flush = 1'b1;
        @(negedge clock);                               // cycle 13
        flush = 1'b0;
        check_vec("overflow_flush", pack_exp(0, acc_col[1], 0, 0, 0, 0, 0));
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check_vec("overflow_quiet", pack_exp(0, acc_col[1], 0, 0, 0, 0, 0));
        end
    endtask

    task automatic test_flush_on();
        do_reset();
        clear_sched();
        sch_wr[0] = 1; sch_col[0] = 2'b01;
        sch_wr[1] = 1; sch_col[1] = 2'b00;
        run_sched("flush_on", 4);
        @(negedge clock);                               // cycle 4: mid on-phase
        check_vec("flush_pre", expect_vec(4));
        flush = 1'b1; wr_en = 1'b1; wr_color = 2'b11;   // write must lose to flush
        @(negedge clock);                               // cycle 5
        flush = 1'b0; wr_en = 1'b0;
        check_vec("flush_off_strobe", pack_exp(1, 2'b01, 0, 0, 0, 0, 0));
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check_vec("flush_quiet", pack_exp(0, 2'b01, 0, 0, 0, 0, 0));
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        clear_sched();
        sch_wr[0] = 1; sch_col[0] = 2'b10;
        run_sched("reset_mid_pre", 4);
        #2 reset = 1'b1;
        #1 check_vec("reset_async", 15'b0);
        @(negedge clock);
        reset = 1'b0;
        clear_sched();
        sch_wr[0] = 1; sch_col[0] = 2'b11;
        run_sched("reset_mid_post", 12);
    endtask

    task automatic test_random();
        int dens [4] = '{10, 25, 50, 90};
        for (int r = 0; r < 4; r++) begin
            do_reset();
            clear_sched();
            for (int c = 0; c < 60; c++) begin
                sch_wr[c]  = ($urandom_range(0, 99) < dens[r]);
                sch_col[c] = 2'($urandom_range(0, 3));
            end
            run_sched("random", 100);
        end
    endtask

    initial begin
        test_reset();
        test_single_blue();
        test_back_to_back();
        test_overflow();
        test_flush_on();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
